// File: rtl/ex_stage_mc.sv
// ex_stage_mc -- multi-cycle execute stage.
//
// Single-cycle ops: ADD, SUB, AND, NOR and LHB, plus shifts by zero.
// These load the result register on the accept edge.
// Shifts by N>0 run one bit per clock in a working register and
// deliver their result N edges after the accept edge.
// The result register holds dst and its flags under a valid/ready handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation request / stage can accept
//   func                000 ADD, 001 SUB, 010 AND, 011 NOR,
//                       100 SLL, 101 SRL, 110 SRA, 111 LHB
//   shamt               shift amount
//   src1sel             0: src1 = p1, 1: src1 = sign-extended imm
//   src0, p1, imm       operands
//   out_valid/out_ready result handshake
//   dst, zr, ov, neg    registered result, zero, signed overflow, negative

module ex_stage_mc #(
   parameter int WIDTH   = 16,
   parameter int IMM_W   = 8,
   parameter int SHAMT_W = 4,
   parameter int SAT     = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         func,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               src1sel,
   input  logic [WIDTH-1:0]   src0,
   input  logic [WIDTH-1:0]   p1,
   input  logic [IMM_W-1:0]   imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   dst,
   output logic               zr,
   output logic               ov,
   output logic               neg
);

   localparam logic [2:0] FN_ADD = 3'b000;
   localparam logic [2:0] FN_SUB = 3'b001;
   localparam logic [2:0] FN_AND = 3'b010;
   localparam logic [2:0] FN_NOR = 3'b011;
   localparam logic [2:0] FN_SLL = 3'b100;
   localparam logic [2:0] FN_SRL = 3'b101;
   localparam logic [2:0] FN_SRA = 3'b110;
   localparam logic [2:0] FN_LHB = 3'b111;

   localparam logic               SAT_EN    = (SAT != 0);
   localparam logic [WIDTH-1:0]   SMAX      = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   SMIN      = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};
   localparam logic [SHAMT_W-1:0] CNT_ZERO  = {SHAMT_W{1'b0}};
   localparam logic [SHAMT_W-1:0] CNT_ONE   = {{(SHAMT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [SHAMT_W-1:0] cnt_r;
   logic [WIDTH-1:0]   work_r;
   logic [1:0]         kind_r;

   logic [WIDTH-1:0]   dst_r;
   logic               zr_r;
   logic               ov_r;
   logic               neg_r;
   logic               out_valid_r;

   logic [WIDTH-1:0]   src1_s;
   logic [WIDTH-1:0]   sum_s;
   logic [WIDTH-1:0]   diff_s;
   logic               add_ov_s;
   logic               sub_ov_s;
   logic [WIDTH-1:0]   alu_res_s;
   logic               alu_ov_s;
   logic [WIDTH-1:0]   step_s;
   logic               in_ready_s;
   logic               accept_s;
   logic               is_shift_s;
   logic               start_shift_s;
   logic               load_s;
   logic [WIDTH-1:0]   res_s;
   logic               res_ov_s;

   // Saturation value follows the sign of src0: only same-sign-as-src0 overflow is possible.
   function automatic logic [WIDTH-1:0] sat_value(input logic src0_neg);
      return src0_neg ? SMIN : SMAX;
   endfunction

   assign src1_s   = src1sel ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : p1;
   assign sum_s    = src0 + src1_s;
   assign diff_s   = src0 - src1_s;
   assign add_ov_s = (src0[WIDTH-1] == src1_s[WIDTH-1]) && (sum_s[WIDTH-1]  != src0[WIDTH-1]);
   assign sub_ov_s = (src0[WIDTH-1] != src1_s[WIDTH-1]) && (diff_s[WIDTH-1] != src0[WIDTH-1]);

   assign is_shift_s = (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
   assign in_ready_s = (state_r == IDLE) && (!out_valid_r || out_ready) && !rst;
   assign accept_s   = in_valid && in_ready_s;

   // Single-cycle ALU result; shift cases only reach dst when shamt is zero.
   always_comb begin
      alu_res_s = src0;
      alu_ov_s  = 1'b0;
      case (func)
         FN_ADD: begin
            alu_ov_s = add_ov_s;
            if (SAT_EN && add_ov_s) begin
               alu_res_s = sat_value(src0[WIDTH-1]);
            end else begin
               alu_res_s = sum_s;
            end
         end
         FN_SUB: begin
            alu_ov_s = sub_ov_s;
            if (SAT_EN && sub_ov_s) begin
               alu_res_s = sat_value(src0[WIDTH-1]);
            end else begin
               alu_res_s = diff_s;
            end
         end
         FN_AND:  alu_res_s = src0 & src1_s;
         FN_NOR:  alu_res_s = ~(src0 | src1_s);
         FN_LHB:  alu_res_s = {imm, src0[WIDTH-IMM_W-1:0]};
         FN_SLL,
         FN_SRL,
         FN_SRA:  alu_res_s = src0;
         default: alu_res_s = src0;
      endcase
   end

   // One-bit shift of the working register; kind_r holds func[1:0] of the shift op.
   always_comb begin
      step_s = work_r;
      case (kind_r)
         2'b00:   step_s = {work_r[WIDTH-2:0], 1'b0};
         2'b01:   step_s = {1'b0, work_r[WIDTH-1:1]};
         2'b10:   step_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
         default: step_s = work_r;
      endcase
   end

   // Next-state logic and selection of the value to load into the result register.
   always_comb begin
      state_nx_s    = state_r;
      start_shift_s = 1'b0;
      load_s        = 1'b0;
      res_s         = alu_res_s;
      res_ov_s      = alu_ov_s;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (is_shift_s && (shamt != CNT_ZERO)) begin
                  state_nx_s    = SHIFT;
                  start_shift_s = 1'b1;
               end else begin
                  load_s = 1'b1;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CNT_ONE) begin
               state_nx_s = IDLE;
               load_s     = 1'b1;
               res_s      = step_s;
               res_ov_s   = 1'b0;
            end else begin
               state_nx_s = SHIFT;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // FSM state, shift counter and working register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         work_r  <= ZERO_W;
         kind_r  <= 2'b00;
      end else begin
         state_r <= state_nx_s;
         if (start_shift_s) begin
            cnt_r  <= shamt;
            work_r <= src0;
            kind_r <= func[1:0];
         end else if (state_r == SHIFT) begin
            cnt_r  <= cnt_r - CNT_ONE;
            work_r <= step_s;
         end else begin
            cnt_r  <= cnt_r;
            work_r <= work_r;
         end
      end
   end

   // Result register: a new load wins over a same-edge drain, otherwise hold under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         dst_r       <= ZERO_W;
         zr_r        <= 1'b0;
         ov_r        <= 1'b0;
         neg_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         dst_r       <= res_s;
         zr_r        <= (res_s == ZERO_W);
         ov_r        <= res_ov_s;
         neg_r       <= res_s[WIDTH-1];
         out_valid_r <= 1'b1;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign dst       = dst_r;
   assign zr        = zr_r;
   assign ov        = ov_r;
   assign neg       = neg_r;

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16: datapath width in bits, legal range 8 to 64.
REQ-002 The block SHALL have parameter IMM_W, default 8: immediate field width in bits, legal range 1 to WIDTH-1.
REQ-003 The block SHALL have parameter SHAMT_W, default 4: shift-amount width, equal to ceil(log2(WIDTH)).
REQ-004 The block SHALL have parameter SAT, default 0: 1 selects saturating ADD/SUB, 0 selects wrapping ADD/SUB.

Ports:
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid  input  1  operation request.
REQ-008 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-009 The block SHALL have port func  input  3  op: 000 ADD, 001 SUB, 010 AND, 011 NOR, 100 SLL, 101 SRL, 110 SRA, 111 LHB.
REQ-010 The block SHALL have port shamt  input  SHAMT_W  shift amount.
REQ-011 The block SHALL have port src1sel  input  1  0 selects p1 as src1; 1 selects sign-extended imm as src1.
REQ-012 The block SHALL have port src0  input  WIDTH  first operand.
REQ-013 The block SHALL have port p1  input  WIDTH  register-file second operand.
REQ-014 The block SHALL have port imm  input  IMM_W  immediate field.
REQ-015 The block SHALL have port out_valid  output  1  dst and flags hold a result.
REQ-016 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-017 The block SHALL have ports dst  output  WIDTH, and zr, ov, neg  output  1 each: registered result, zero flag, signed-overflow flag, negative flag.

Function
REQ-018 An operation SHALL be accepted on a rising edge where in_valid && in_ready; inputs are sampled only on that edge.
REQ-019 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !rst.
REQ-020 src1 SHALL equal p1 when src1sel=0, otherwise imm sign-extended to WIDTH.
REQ-021 ADD and SUB SHALL compute src0+src1 and src0-src1 modulo 2^WIDTH, and set ov on two's-complement signed overflow.
REQ-022 When SAT=1 and ADD/SUB overflows, dst SHALL be the signed max (0111..1) for positive overflow or the signed min (1000..0) for negative overflow, and ov SHALL still be 1.
REQ-023 AND SHALL compute src0&src1, NOR SHALL compute ~(src0|src1), and LHB SHALL compute {imm, src0[WIDTH-IMM_W-1:0]}; ov SHALL be 0 for all three.
REQ-024 SLL and SRL SHALL shift src0 with zero fill, and SRA SHALL shift src0 with MSB fill, by shamt bit positions; ov SHALL be 0.
REQ-025 The block SHALL have FSM states IDLE and SHIFT.
REQ-026 A non-shift op, or a shift op with shamt=0, SHALL load dst and flags and set out_valid on the accept edge, and the FSM SHALL remain in IDLE.
REQ-027 A shift op with shamt=N>0 SHALL, on the accept edge, load a working register with src0 and a counter with N, and move to SHIFT.
REQ-028 In SHIFT, each edge SHALL shift the working register by one bit and decrement the counter.
REQ-029 On the edge where the counter goes from 1 to 0, the shifted value SHALL load dst and flags, out_valid SHALL be set, and the FSM SHALL return to IDLE.
REQ-030 out_valid SHALL therefore rise exactly N edges after the accept edge.
REQ-031 zr SHALL be (dst==0) and neg SHALL be dst[WIDTH-1], both registered together with dst.
REQ-032 While out_valid && !out_ready, dst, zr, ov, neg and out_valid SHALL hold stable.
REQ-033 out_valid SHALL clear on an edge with out_ready=1 unless a new result loads on the same edge; a same-edge drain plus load SHALL set out_valid=1 with the new result.
REQ-034 in_valid with any func SHALL be ignored while in SHIFT, and in_ready SHALL be 0 throughout SHIFT.

Reset
REQ-035 On any edge with rst=1, the block SHALL set state=IDLE, counter=0, working register=0, dst=0, zr=0, ov=0, neg=0 and out_valid=0, aborting any in-progress shift with no result produced.
REQ-036 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-037 The bench SHALL cover, with WIDTH=16 and SAT=0: ADD 0x7FFF+0x0001 -> one edge after accept, dst=0x8000, ov=1, neg=1, zr=0; repeated with SAT=1 -> dst=0x7FFF, ov=1, neg=0.
REQ-038 The bench SHALL cover: SUB, src1sel=1, imm=0xFF, src0=0x0000 -> src1=0xFFFF, dst=0x0001, ov=0; AND 0x00F0 & 0x0F00 -> dst=0x0000, zr=1.
REQ-039 The bench SHALL cover: SRA src0=0x8000, shamt=15 -> in_ready=0 for 15 cycles, out_valid rises 15 edges after accept, dst=0xFFFF, neg=1; SRL with the same operands -> dst=0x0001.
REQ-040 The bench SHALL cover backpressure: result valid with out_ready=0 for 3 cycles -> dst and flags unchanged and in_ready=0; then out_ready=1 with in_valid=1 (ADD 2+3) -> drain and accept on the same edge, next dst=0x0005, out_valid stays 1.
REQ-041 The bench SHALL cover reset mid-operation: SLL shamt=10 with rst pulsed at the 5th SHIFT edge -> out_valid=0, dst=0x0000, in_ready=1 in the next cycle, and no stale result ever appears.
REQ-042 The bench SHALL cover LHB: imm=0xAB, src0=0x1234 -> dst=0xAB34, ov=0, neg=1.
